// File: rtl/cmplx_frame_accum.sv
// cmplx_frame_accum: sums a frame of L complex products into wide saturating
// accumulators and presents each frame sum on a valid/ready output register.
// The real and imaginary components are accumulated and clamped independently.
module cmplx_frame_accum #(
  parameter int N     = 8,
  parameter int L     = 16,
  parameter int ACC_W = 2*N+4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2*N-1:0]   in_r,
  input  logic [2*N-1:0]   in_i,
  input  logic             clear,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_r,
  output logic [ACC_W-1:0] out_i,
  output logic             out_ovf,
  output logic             overrun
);

  localparam int               CNT_W   = (L > 2) ? $clog2(L) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(L-1);
  localparam logic [ACC_W-1:0] SAT_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
  localparam int               EXT_W    = ACC_W + 1 - 2*N;

  // Accumulator state for the frame in progress.
  logic [ACC_W-1:0] r_acc_r;
  logic [ACC_W-1:0] r_acc_i;
  logic [CNT_W-1:0] r_cnt;
  logic             r_frame_ovf;

  // Output register set.
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_r;
  logic [ACC_W-1:0] r_out_i;
  logic             r_out_ovf;
  logic             r_overrun;

  // One guard bit above the accumulator width: both operands fit in ACC_W
  // signed bits, so their sum always fits in ACC_W+1 without wrapping.
  logic [ACC_W:0]   w_sum_r;
  logic [ACC_W:0]   w_sum_i;
  logic [ACC_W-1:0] w_sat_r;
  logic [ACC_W-1:0] w_sat_i;
  logic             w_ovf_r;
  logic             w_ovf_i;
  logic             w_take;
  logic             w_last;
  logic             w_done;

  assign w_sum_r = {r_acc_r[ACC_W-1], r_acc_r} + {{EXT_W{in_r[2*N-1]}}, in_r};
  assign w_sum_i = {r_acc_i[ACC_W-1], r_acc_i} + {{EXT_W{in_i[2*N-1]}}, in_i};

  // clear discards any sample presented in the same cycle.
  assign w_take = in_valid && !clear;
  assign w_last = (r_cnt == CNT_LAST);
  assign w_done = w_take && w_last;

  // Clamp each component when the guard bit disagrees with the sign bit.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    w_sat_r = w_sum_r[ACC_W-1:0];
    w_sat_i = w_sum_i[ACC_W-1:0];
    w_ovf_r = 1'b0;
    w_ovf_i = 1'b0;
    if (w_sum_r[ACC_W] != w_sum_r[ACC_W-1]) begin
      w_ovf_r = 1'b1;
      w_sat_r = w_sum_r[ACC_W] ? SAT_MIN : SAT_MAX;
    end
    if (w_sum_i[ACC_W] != w_sum_i[ACC_W-1]) begin
      w_ovf_i = 1'b1;
      w_sat_i = w_sum_i[ACC_W] ? SAT_MIN : SAT_MAX;
    end
  end

  // Frame accumulation: add each accepted sample, restart after the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_r     <= '0;
      r_acc_i     <= '0;
      r_cnt       <= '0;
      r_frame_ovf <= 1'b0;
    end else if (clear || w_done) begin
      // NOTE: state registers use non-blocking assignments so every register
      // here sees the pre-edge values of the others, as the hardware does.
      r_acc_r     <= '0;
      r_acc_i     <= '0;
      r_cnt       <= '0;
      r_frame_ovf <= 1'b0;
    end else if (w_take) begin
      r_acc_r     <= w_sat_r;
      r_acc_i     <= w_sat_i;
      r_cnt       <= r_cnt + CNT_W'(1);
      r_frame_ovf <= r_frame_ovf | w_ovf_r | w_ovf_i;
    end
  end

  // Output register: load on frame completion, drop valid after a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_r     <= '0;
      r_out_i     <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_done) begin
      r_out_valid <= 1'b1;
      r_out_r     <= w_sat_r;
      r_out_i     <= w_sat_i;
      r_out_ovf   <= r_frame_ovf | w_ovf_r | w_ovf_i;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky overrun: a completed frame replaced a result nobody accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (clear) begin
      r_overrun <= 1'b0;
    end else if (w_done && r_out_valid && !out_ready) begin
      r_overrun <= 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_r     = r_out_r;
  assign out_i     = r_out_i;
  assign out_ovf   = r_out_ovf;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_cmplx_frame_accum.sv
// Bench for cmplx_frame_accum: two instances (ACC_W=20 and ACC_W=17) share one
// stimulus stream and are compared every cycle against a frame-level model.
module tb_cmplx_frame_accum;

  localparam int N  = 8;
  localparam int L  = 4;
  localparam int AW = 20;
  localparam int SW = 17;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [15:0]   in_r;
  logic [15:0]   in_i;
  logic          clear;
  logic          out_ready;

  logic          out_valid_a, out_ovf_a, overrun_a;
  logic [AW-1:0] out_r_a, out_i_a;
  logic          out_valid_s, out_ovf_s, overrun_s;
  logic [SW-1:0] out_r_s, out_i_s;

  int n_checks = 0;
  int n_errors = 0;

  cmplx_frame_accum #(.N(N), .L(L), .ACC_W(AW)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_r(in_r), .in_i(in_i),
    .clear(clear), .out_ready(out_ready), .out_valid(out_valid_a),
    .out_r(out_r_a), .out_i(out_i_a), .out_ovf(out_ovf_a), .overrun(overrun_a)
  );

  cmplx_frame_accum #(.N(N), .L(L), .ACC_W(SW)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_r(in_r), .in_i(in_i),
    .clear(clear), .out_ready(out_ready), .out_valid(out_valid_s),
    .out_r(out_r_s), .out_i(out_i_s), .out_ovf(out_ovf_s), .overrun(overrun_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the samples of the current frame are kept in queues and
  // folded with clamped integer arithmetic when the frame completes.
  longint q_r[$];
  longint q_i[$];
  int     acc_w[2] = '{AW, SW};
  bit     m_valid[2];
  longint m_r[2];
  longint m_i[2];
  bit     m_ovf[2];
  bit     m_ovr[2];

  function automatic void fold(input int aw, output longint sr,
                               output longint si, output bit ov);
    longint hi = (longint'(1) << (aw - 1)) - 1;
    longint lo = -hi - 1;
    sr = 0; si = 0; ov = 1'b0;
    foreach (q_r[j]) begin
      sr = sr + q_r[j];
      if (sr > hi) begin sr = hi; ov = 1'b1; end
      else if (sr < lo) begin sr = lo; ov = 1'b1; end
      si = si + q_i[j];
      if (si > hi) begin si = hi; ov = 1'b1; end
      else if (si < lo) begin si = lo; ov = 1'b1; end
    end
  endfunction

  task automatic model_edge();
    bit     done = 1'b0;
    longint sr, si;
    bit     ov;
    if (clear) begin
      q_r.delete(); q_i.delete();
    end else if (in_valid) begin
      q_r.push_back(longint'($signed(in_r)));
      q_i.push_back(longint'($signed(in_i)));
      if (q_r.size() == L) done = 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      if (clear) m_ovr[k] = 1'b0;
      if (done) begin
        fold(acc_w[k], sr, si, ov);
        if (m_valid[k] && !out_ready) m_ovr[k] = 1'b1;
        m_valid[k] = 1'b1;
        m_r[k] = sr; m_i[k] = si; m_ovf[k] = ov;
      end else if (m_valid[k] && out_ready) begin
        m_valid[k] = 1'b0;
      end
    end
    if (done) begin q_r.delete(); q_i.delete(); end
  endtask

  task automatic model_reset();
    q_r.delete(); q_i.delete();
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 1'b0; m_r[k] = 0; m_i[k] = 0; m_ovf[k] = 1'b0; m_ovr[k] = 1'b0;
    end
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, " a.valid"},   longint'(out_valid_a),       longint'(m_valid[0]));
    check({tag, " a.r"},       longint'($signed(out_r_a)),  m_r[0]);
    check({tag, " a.i"},       longint'($signed(out_i_a)),  m_i[0]);
    check({tag, " a.ovf"},     longint'(out_ovf_a),         longint'(m_ovf[0]));
    check({tag, " a.overrun"}, longint'(overrun_a),         longint'(m_ovr[0]));
    check({tag, " s.valid"},   longint'(out_valid_s),       longint'(m_valid[1]));
    check({tag, " s.r"},       longint'($signed(out_r_s)),  m_r[1]);
    check({tag, " s.i"},       longint'($signed(out_i_s)),  m_i[1]);
    check({tag, " s.ovf"},     longint'(out_ovf_s),         longint'(m_ovf[1]));
    check({tag, " s.overrun"}, longint'(overrun_s),         longint'(m_ovr[1]));
  endtask

  task automatic drive(input bit v, input int r, input int i, input bit clr, input bit rdy);
    in_valid  = v;
    in_r      = 16'(r);
    in_i      = 16'(i);
    clear     = clr;
    out_ready = rdy;
  endtask

  // One clock: the model consumes the pre-edge inputs, the DUT is sampled 1 after.
  task automatic cyc(input bit v, input int r, input int i, input bit clr,
                     input bit rdy, input string tag);
    drive(v, r, i, clr, rdy);
    model_edge();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  // Asynchronous reset: outputs must read zero before any clock edge.
  task automatic apply_reset();
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    rst = 1'b1;
    model_reset();
    #1;
    compare_all("reset async");
    @(posedge clk);
    #1;
    compare_all("reset held");
    rst = 1'b0;
  endtask

  typedef struct {
    bit vld; int r; int i; bit clr; bit rdy;
    bit e_vld; int e_r; int e_i; bit e_ovf; bit e_ovr;
  } vec_t;

  vec_t tbl[5];

  initial begin
    rst = 1'b1;
    drive(1'b0, 0, 0, 1'b0, 1'b0);

    tbl[0] = '{1'b1,  100, -50, 1'b0, 1'b1, 1'b0,   0, 0, 1'b0, 1'b0};
    tbl[1] = '{1'b1,  200,  50, 1'b0, 1'b1, 1'b0,   0, 0, 1'b0, 1'b0};
    tbl[2] = '{1'b1,  -30,   0, 1'b0, 1'b1, 1'b0,   0, 0, 1'b0, 1'b0};
    tbl[3] = '{1'b1,    1,   1, 1'b0, 1'b1, 1'b1, 271, 1, 1'b0, 1'b0};
    tbl[4] = '{1'b0,    0,   0, 1'b0, 1'b1, 1'b0, 271, 1, 1'b0, 1'b0};

    // Reset in the middle of a frame while a result is pending.
    apply_reset();
    for (int s = 0; s < 4; s++) cyc(1'b1, 3, 3, 1'b0, 1'b0, "pre-reset frame");
    for (int s = 0; s < 2; s++) cyc(1'b1, 7, 7, 1'b0, 1'b0, "partial frame");
    apply_reset();
    for (int s = 0; s < 4; s++) cyc(1'b1, 1, 2, 1'b0, 1'b1, "post-reset frame");
    check("post-reset valid", longint'(out_valid_a), 1);
    check("post-reset r", longint'($signed(out_r_a)), 4);
    check("post-reset i", longint'($signed(out_i_a)), 8);

    // Basic contiguous frame from the vector table.
    apply_reset();
    for (int v = 0; v < 5; v++) begin
      cyc(tbl[v].vld, tbl[v].r, tbl[v].i, tbl[v].clr, tbl[v].rdy, "table");
      check("tbl valid",   longint'(out_valid_a),      longint'(tbl[v].e_vld));
      check("tbl r",       longint'($signed(out_r_a)), longint'(tbl[v].e_r));
      check("tbl i",       longint'($signed(out_i_a)), longint'(tbl[v].e_i));
      check("tbl ovf",     longint'(out_ovf_a),        longint'(tbl[v].e_ovf));
      check("tbl overrun", longint'(overrun_a),        longint'(tbl[v].e_ovr));
    end

    // Same samples with three idle cycles between each.
    for (int s = 0; s < 4; s++) begin
      cyc(1'b1, tbl[s].r, tbl[s].i, 1'b0, 1'b1, "gap sample");
      if (s < 3) begin
        check("gap no early valid", longint'(out_valid_a), 0);
        for (int g = 0; g < 3; g++) cyc(1'b0, 0, 0, 1'b0, 1'b1, "gap idle");
      end
    end
    check("gap valid", longint'(out_valid_a), 1);
    check("gap r", longint'($signed(out_r_a)), 271);
    check("gap i", longint'($signed(out_i_a)), 1);
    cyc(1'b0, 0, 0, 1'b0, 1'b1, "gap drain");
    check("gap one-cycle valid", longint'(out_valid_a), 0);

    // Saturation on the narrow instance, then a clean frame.
    for (int s = 0; s < 4; s++) cyc(1'b1, 32767, -32768, 1'b0, 1'b1, "sat frame");
    check("sat r", longint'($signed(out_r_s)), 65535);
    check("sat i", longint'($signed(out_i_s)), -65536);
    check("sat ovf", longint'(out_ovf_s), 1);
    check("wide no-sat r", longint'($signed(out_r_a)), 131068);
    for (int s = 0; s < 4; s++) cyc(1'b1, 1, 1, 1'b0, 1'b1, "post-sat frame");
    check("post-sat r", longint'($signed(out_r_s)), 4);
    check("post-sat i", longint'($signed(out_i_s)), 4);
    check("post-sat ovf", longint'(out_ovf_s), 0);

    // Backpressure: second frame overwrites an unaccepted result.
    for (int s = 0; s < 4; s++) cyc(1'b1, 1, 0, 1'b0, 1'b0, "bp frame1");
    for (int s = 0; s < 4; s++) cyc(1'b1, 2, 0, 1'b0, 1'b0, "bp frame2");
    check("bp r", longint'($signed(out_r_a)), 8);
    check("bp overrun", longint'(overrun_a), 1);
    cyc(1'b0, 0, 0, 1'b0, 1'b1, "bp accept");
    check("bp valid drop", longint'(out_valid_a), 0);
    check("bp overrun sticky", longint'(overrun_a), 1);
    cyc(1'b0, 0, 0, 1'b1, 1'b1, "bp clear");
    check("bp overrun cleared", longint'(overrun_a), 0);

    // Clear coinciding with a sample aborts the partial frame.
    for (int s = 0; s < 2; s++) cyc(1'b1, 5, 5, 1'b0, 1'b1, "clr partial");
    cyc(1'b1, 9, 9, 1'b1, 1'b1, "clr with sample");
    for (int s = 0; s < 4; s++) cyc(1'b1, 1, -1, 1'b0, 1'b1, "clr next frame");
    check("clr r", longint'($signed(out_r_a)), 4);
    check("clr i", longint'($signed(out_i_a)), -4);

    // Randomized traffic, extremes mixed in to exercise the clamps.
    for (int c = 0; c < 600; c++) begin
      int r, i;
      r = int'($signed(16'($urandom)));
      i = int'($signed(16'($urandom)));
      if ($urandom_range(0, 3) == 0) r = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
      if ($urandom_range(0, 3) == 0) i = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
      cyc($urandom_range(0, 3) != 0, r, i, $urandom_range(0, 19) == 0,
          $urandom_range(0, 1) != 0, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
